freq_period_meter: RTL and testbench

Downstream consumer of the frequency divider output. Synchronises the divided `frequency` square wave into the `clk` domain, detects its edges and measures period and high time in `clk` cycles. Each completed period produces a one-cycle `valid` pulse. Over-long periods are flagged rather than wrapped. Results feed status/debug logic and let the bench check divider ratios without waveform inspection.

---
 rtl/freq_period_meter.sv | 141 ++++++++++++++
 tb/tb_freq_period_meter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/freq_period_meter.sv
// freq_period_meter
// Measures the period and high time of an asynchronous square wave in clk
// cycles. The input is synchronised (SYNC_STAGES >= 2 flops plus one delay
// flop for edge detection), then a three-state FSM counts cycles between
// rising edges. Each closed period gives a one-cycle valid pulse; a period
// that would not fit in WIDTH bits raises a sticky overflow flag and re-arms.
module freq_period_meter #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frequency,
    input  logic             enable,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t                 state;
    state_t                 state_next;

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic                   s_d;
    logic                   rise;
    logic                   fall;

    logic [WIDTH-1:0]       cnt;
    logic [WIDTH-1:0]       cnt_next;
    logic [WIDTH-1:0]       ht;
    logic [WIDTH-1:0]       ht_next;
    logic [WIDTH-1:0]       period_next;
    logic [WIDTH-1:0]       high_time_next;
    logic                   valid_next;
    logic                   overflow_next;

    assign s    = sync[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    // Synchroniser chain for the asynchronous input, plus one delay flop for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync <= '0;
            s_d  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], frequency};
            s_d  <= s;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath update; a rise coinciding with a full counter closes the period
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        ht_next        = ht;
        period_next    = period;
        high_time_next = high_time;
        valid_next     = 1'b0;
        overflow_next  = overflow;

        if (!enable) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_next   = '0;
                    state_next = ARM;
                end
                ARM: begin
                    if (rise) begin
                        cnt_next   = CNT_ONE;
                        state_next = MEASURE;
                    end
                end
                MEASURE: begin
                    cnt_next = cnt + CNT_ONE;
                    if (fall) begin
                        ht_next = cnt;
                    end
                    if (rise) begin
                        period_next    = cnt;
                        high_time_next = ht;
                        valid_next     = 1'b1;
                        overflow_next  = 1'b0;
                        cnt_next       = CNT_ONE;
                    end else if (cnt == CNT_MAX) begin
                        overflow_next = 1'b1;
                        cnt_next      = '0;
                        state_next    = ARM;
                    end
                end
                default: begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Counter, high-time shadow and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            ht        <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            cnt       <= cnt_next;
            ht        <= ht_next;
            period    <= period_next;
            high_time <= high_time_next;
            valid     <= valid_next;
            overflow  <= overflow_next;
        end
    end

endmodule

// File: tb/tb_freq_period_meter.sv
// Testbench for freq_period_meter: two instances (WIDTH 16 and WIDTH 4) share
// the same stimulus. A timestamp-based reference model predicts every output
// each cycle; directed phases add fixed-value checks at the boundary cases.
module tb_freq_period_meter;

    localparam int SS = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        frequency = 1'b0;
    logic        enable = 1'b1;

    logic [15:0] p16, h16;
    logic        v16, o16;
    logic [3:0]  p4, h4;
    logic        v4, o4;

    int checks = 0;
    int errors = 0;

    freq_period_meter #(.WIDTH(16), .SYNC_STAGES(SS)) dut16 (
        .clk(clk), .reset(reset), .frequency(frequency), .enable(enable),
        .period(p16), .high_time(h16), .valid(v16), .overflow(o16)
    );

    freq_period_meter #(.WIDTH(4), .SYNC_STAGES(SS)) dut4 (
        .clk(clk), .reset(reset), .frequency(frequency), .enable(enable),
        .period(p4), .high_time(h4), .valid(v4), .overflow(o4)
    );

    always #5 clk = ~clk;

    // Reference model: timestamps of detected edges; index 0 is WIDTH 16, index 1 is WIDTH 4
    bit          hist[$];
    int unsigned cyc;
    int          ph[2];
    int unsigned start_at[2], hv[2], m_period[2], m_high[2];
    bit          m_valid[2], m_ovf[2];
    bit          m_rise, m_fall;
    int unsigned elapsed, lim;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist.delete();
            repeat (SS + 1) hist.push_back(1'b0);
            cyc = 0;
            for (int i = 0; i < 2; i++) begin
                ph[i] = 0; start_at[i] = 0; hv[i] = 0;
                m_period[i] = 0; m_high[i] = 0; m_valid[i] = 0; m_ovf[i] = 0;
            end
        end else begin
            m_rise = hist[SS-1] && !hist[SS];
            m_fall = !hist[SS-1] && hist[SS];
            hist.push_front(frequency);
            void'(hist.pop_back());
            for (int i = 0; i < 2; i++) begin
                lim = (i == 0) ? 32'd65535 : 32'd15;
                m_valid[i] = 0;
                if (!enable) begin
                    ph[i] = 0;
                end else if (ph[i] == 0) begin
                    ph[i] = 1;
                end else if (ph[i] == 1) begin
                    if (m_rise) begin
                        ph[i] = 2;
                        start_at[i] = cyc;
                    end
                end else begin
                    elapsed = cyc - start_at[i];
                    if (m_fall) hv[i] = elapsed;
                    if (m_rise) begin
                        m_period[i] = elapsed;
                        m_high[i]   = hv[i];
                        m_valid[i]  = 1;
                        m_ovf[i]    = 0;
                        start_at[i] = cyc;
                    end else if (elapsed == lim) begin
                        m_ovf[i] = 1;
                        ph[i]    = 1;
                    end
                end
            end
            cyc++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic compare_all();
        check("w16.valid",     {31'b0, v16}, {31'b0, m_valid[0]});
        check("w16.overflow",  {31'b0, o16}, {31'b0, m_ovf[0]});
        check("w16.period",    {16'b0, p16}, m_period[0]);
        check("w16.high_time", {16'b0, h16}, m_high[0]);
        check("w4.valid",      {31'b0, v4},  {31'b0, m_valid[1]});
        check("w4.overflow",   {31'b0, o4},  {31'b0, m_ovf[1]});
        check("w4.period",     {28'b0, p4},  m_period[1]);
        check("w4.high_time",  {28'b0, h4},  m_high[1]);
    endtask

    task automatic step(input logic f);
        @(negedge clk);
        compare_all();
        frequency = f;
    endtask

    task automatic run_wave(input int hi, input int lo, input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < hi; i++) step(1'b1);
            for (int i = 0; i < lo; i++) step(1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  c;
        bit  fired;

        // Reset held with the input toggling
        enable = 1'b1;
        for (int i = 0; i < 5; i++) step(i[0] ? 1'b0 : 1'b1);
        check("reset.period", {16'b0, p16}, 32'd0);
        check("reset.valid",  {31'b0, v16}, 32'd0);
        reset = 1'b1;

        // clk/2 input
        run_wave(1, 1, 10);
        check("clk2.period", {16'b0, p16}, 32'd2);
        check("clk2.high",   {16'b0, h16}, 32'd1);

        // 5/5 then 3/7
        run_wave(5, 5, 4);
        check("h5l5.period", {16'b0, p16}, 32'd10);
        check("h5l5.high",   {16'b0, h16}, 32'd5);
        run_wave(3, 7, 2);
        check("h3l7.period", {16'b0, p16}, 32'd10);
        check("h3l7.high",   {16'b0, h16}, 32'd3);

        // Held high: WIDTH 4 overflows, WIDTH 16 does not
        for (int i = 0; i < 20; i++) step(1'b1);
        check("ovf.w4_flag",   {31'b0, o4},  32'd1);
        check("ovf.w4_hold",   {28'b0, p4},  32'd10);
        check("ovf.w16_flag",  {31'b0, o16}, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0);
        run_wave(3, 3, 4);
        check("ovf.recover_period", {28'b0, p4}, 32'd6);
        check("ovf.recover_flag",   {31'b0, o4}, 32'd0);

        // 15-cycle period: rise at full count wins; 16 cycles overflows
        run_wave(8, 7, 3);
        check("max.period", {28'b0, p4}, 32'd15);
        check("max.high",   {28'b0, h4}, 32'd8);
        check("max.flag",   {31'b0, o4}, 32'd0);
        run_wave(9, 7, 3);
        check("max1.flag",   {31'b0, o4},  32'd1);
        check("max1.hold",   {28'b0, p4},  32'd15);
        check("max1.w16",    {16'b0, p16}, 32'd16);

        // Enable dropped midway through a 10-cycle period
        run_wave(5, 5, 3);
        for (int k = 0; k < 40; k++) begin
            enable = !(k >= 7 && k < 12);
            step(((k % 10) < 5) ? 1'b1 : 1'b0);
        end
        enable = 1'b1;
        check("endrop.period", {16'b0, p16}, 32'd10);
        check("endrop.high",   {16'b0, h16}, 32'd5);

        // Randomised waves with occasional enable drops
        for (int w = 0; w < 40; w++) begin
            enable = ($urandom_range(0, 7) != 0);
            run_wave(int'($urandom_range(1, 12)), int'($urandom_range(1, 12)), 1);
        end
        enable = 1'b1;

        // Reset asserted three cycles before an expected valid
        c = 0;
        fired = 0;
        while (!fired && c < 60) begin
            step(((c % 10) < 5) ? 1'b1 : 1'b0);
            c++;
            if (m_valid[0] && c >= 20) begin
                for (int k = 0; k < 7; k++) begin
                    step(((c % 10) < 5) ? 1'b1 : 1'b0);
                    c++;
                end
                fired = 1;
            end
        end
        check("rst.setup", {31'b0, fired}, 32'd1);
        check("rst.pre_period", {16'b0, p16}, 32'd10);
        reset = 1'b0;
        #1;
        check("rst.period", {16'b0, p16}, 32'd0);
        check("rst.high",   {16'b0, h16}, 32'd0);
        check("rst.valid",  {31'b0, v16}, 32'd0);
        check("rst.ovf4",   {31'b0, o4},  32'd0);
        for (int k = 0; k < 4; k++) begin
            step(((c % 10) < 5) ? 1'b1 : 1'b0);
            c++;
        end
        reset = 1'b1;

        // Measurements resume after reset
        run_wave(2, 3, 6);
        check("post.period", {16'b0, p16}, 32'd5);
        check("post.high",   {16'b0, h16}, 32'd2);
        step(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
